// File: rtl/multi_issue_scheduler.sv
// rtl/multi_issue_scheduler.sv - N-wide in-order issue queue with pairing rules and latency scoreboard
module multi_issue_scheduler #(
    parameter int ISSUE_W  = 2,
    parameter int DEPTH    = 8,
    parameter int LOAD_LAT = 2,
    parameter int MC_LAT   = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           single_issue,
    input  logic [$clog2(ISSUE_W+1)-1:0]   push_cnt,
    input  logic [ISSUE_W*57-1:0]          push_data,
    output logic                           push_ready,
    input  logic                           issue_ready,
    output logic [ISSUE_W-1:0]             issue_valid,
    output logic [ISSUE_W*57-1:0]          issue_data,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);
    localparam int EW      = 57;
    localparam int PW      = $clog2(DEPTH);
    localparam int OW      = $clog2(DEPTH+1);
    localparam int PCW     = $clog2(ISSUE_W+1);
    localparam int LAT_MAX = (LOAD_LAT > MC_LAT) ? LOAD_LAT : MC_LAT;
    localparam int CW      = $clog2(LAT_MAX+1);
    localparam logic [CW-1:0] LD_INIT = CW'(LOAD_LAT);
    localparam logic [CW-1:0] MC_INIT = CW'(MC_LAT);

    localparam int B_MRD = 32, B_MWR = 33, B_MC = 34, B_CMOV = 35;
    localparam int B_JMP = 36, B_PRIV = 37, B_FPU = 38, B_SSNOP = 39;
    localparam int B_WE = 40, B_WA = 41, B_R1 = 46, B_R2 = 51, B_DS = 56;

    logic [EW-1:0]  r_mem [DEPTH];
    logic [PW-1:0]  r_head, r_tail;
    logic [OW-1:0]  r_count;
    logic [CW-1:0]  r_sb [32];

    logic [EW-1:0]      w_slot [ISSUE_W];
    logic [ISSUE_W-1:0] w_cand, w_pair_ok, w_issue;
    logic [OW-1:0]      w_pop, w_push;
    logic               w_push_en;

    // Rules that forbid slot k from sharing a group with an earlier issued slot j.
    function automatic logic f_conflict(input logic [EW-1:0] j, input logic [EW-1:0] k);
        logic raw;
        raw = j[B_WE] && (j[B_WA+:5] != 5'd0)
            && ((j[B_WA+:5] == k[B_R1+:5]) || (j[B_WA+:5] == k[B_R2+:5]))
            && (j[B_MRD] || j[B_MC] || k[B_CMOV]);
        return j[B_SSNOP] || k[B_SSNOP] || k[B_FPU] || k[B_PRIV] || k[B_JMP]
            || j[B_JMP] || j[B_DS]
            || ((j[B_MRD] || j[B_MWR]) && (k[B_MRD] || k[B_MWR]))
            || raw || (k[11:0] == 12'd0);
    endfunction

    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            w_slot[k] = r_mem[r_head + PW'(k)];
            issue_data[k*EW +: EW] = w_slot[k];
        end
    end

    always_comb begin
        w_cand    = '0;
        w_pair_ok = '0;
        w_issue   = '0;
        w_pop     = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            w_cand[k] = (OW'(k) < r_count) && issue_ready && !flush
                && !(single_issue && (k > 0))
                && !((w_slot[k][B_R1+:5] != 5'd0) && (r_sb[w_slot[k][B_R1+:5]] != '0))
                && !((w_slot[k][B_R2+:5] != 5'd0) && (r_sb[w_slot[k][B_R2+:5]] != '0));
            w_pair_ok[k] = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (f_conflict(w_slot[j], w_slot[k]))
                    w_pair_ok[k] = 1'b0;
            end
        end
        // Prefix chaining guarantees issue_valid is contiguous from slot 0.
        w_issue[0] = w_cand[0];
        for (int k = 1; k < ISSUE_W; k++)
            w_issue[k] = w_issue[k-1] && w_cand[k] && w_pair_ok[k];
        for (int k = 0; k < ISSUE_W; k++)
            w_pop = w_pop + OW'(w_issue[k]);
    end

    assign issue_valid = w_issue;
    assign occupancy   = r_count;
    assign push_ready  = (r_count <= OW'(DEPTH - ISSUE_W));
    assign w_push_en   = push_ready && (push_cnt != '0) && !flush && !rst;
    assign w_push      = w_push_en ? OW'(push_cnt) : '0;

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            for (int i = 0; i < ISSUE_W; i++) begin
                if (PCW'(i) < push_cnt)
                    r_mem[r_tail + PW'(i)] <= push_data[i*EW +: EW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int r = 0; r < 32; r++)
                r_sb[r] <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (r_sb[r] != '0)
                    r_sb[r] <= r_sb[r] - 1'b1;
            end
            // Later slots overwrite earlier ones, so the highest issuing slot wins.
            for (int k = 0; k < ISSUE_W; k++) begin
                if (w_issue[k] && w_slot[k][B_WE] && (w_slot[k][B_WA+:5] != 5'd0)) begin
                    if (w_slot[k][B_MRD])
                        r_sb[w_slot[k][B_WA+:5]] <= LD_INIT;
                    else if (w_slot[k][B_MC])
                        r_sb[w_slot[k][B_WA+:5]] <= MC_INIT;
                end
            end
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_head  <= r_head + PW'(w_pop);
                r_tail  <= r_tail + PW'(w_push);
                r_count <= r_count + w_push - w_pop;
            end
        end
    end
endmodule

// File: tb/tb_multi_issue_scheduler.sv
// tb/tb_multi_issue_scheduler.sv - directed and randomized checks of multi_issue_scheduler against a queue model
module tb_multi_issue_scheduler;
    localparam int ISSUE_W  = 2;
    localparam int DEPTH    = 8;
    localparam int LOAD_LAT = 2;
    localparam int MC_LAT   = 3;

    localparam logic [7:0] C_MRD = 8'h01, C_MWR = 8'h02, C_MC = 8'h04, C_CMOV = 8'h08;
    localparam logic [7:0] C_JMP = 8'h10, C_PRIV = 8'h20, C_FPU = 8'h40, C_SSNOP = 8'h80;

    typedef logic [56:0] ent_t;

    logic                  clk = 1'b0;
    logic                  rst, flush, single_issue, issue_ready, push_ready;
    logic [1:0]            push_cnt;
    logic [ISSUE_W*57-1:0] push_data, issue_data;
    logic [ISSUE_W-1:0]    issue_valid;
    logic [3:0]            occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t   mq[$];
    longint busy_until [32];
    longint cyc = 0;

    multi_issue_scheduler #(
        .ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .MC_LAT(MC_LAT)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .single_issue(single_issue),
        .push_cnt(push_cnt), .push_data(push_data), .push_ready(push_ready),
        .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_data(issue_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic [7:0] cls, input logic we,
                                input logic [4:0] wa, input logic [4:0] r1, input logic [4:0] r2,
                                input logic ds);
        return {ds, r2, r1, wa, we, cls, pc};
    endfunction

    function automatic logic [7:0] cls_of(input ent_t e); return e[39:32]; endfunction
    function automatic logic [4:0] wa_of(input ent_t e);  return e[45:41]; endfunction
    function automatic logic [4:0] r1_of(input ent_t e);  return e[50:46]; endfunction
    function automatic logic [4:0] r2_of(input ent_t e);  return e[55:51]; endfunction
    function automatic bit is_mem(input ent_t e); return (cls_of(e) & (C_MRD | C_MWR)) != 0; endfunction

    function automatic bit reg_busy(input logic [4:0] r);
        return (r != 0) && (cyc < busy_until[r]);
    endfunction

    // Walk the queue head forward, stopping at the first slot that may not join the group.
    function automatic logic [ISSUE_W-1:0] model_mask(input bit ir, input bit fl, input bit si);
        logic [ISSUE_W-1:0] m;
        m = '0;
        if (!ir || fl) return m;
        for (int k = 0; k < ISSUE_W && k < mq.size(); k++) begin
            ent_t e;
            bit bad;
            e = mq[k];
            if (si && k > 0) break;
            if (reg_busy(r1_of(e)) || reg_busy(r2_of(e))) break;
            bad = 0;
            if (k > 0) begin
                if (e[11:0] == 0) bad = 1;
                if ((cls_of(e) & (C_SSNOP | C_FPU | C_PRIV | C_JMP)) != 0) bad = 1;
                for (int j = 0; j < k; j++) begin
                    ent_t p;
                    p = mq[j];
                    if ((cls_of(p) & (C_SSNOP | C_JMP)) != 0 || p[56]) bad = 1;
                    if (is_mem(p) && is_mem(e)) bad = 1;
                    if (p[40] && wa_of(p) != 0 && (wa_of(p) == r1_of(e) || wa_of(p) == r2_of(e))
                        && ((cls_of(p) & (C_MRD | C_MC)) != 0 || (cls_of(e) & C_CMOV) != 0))
                        bad = 1;
                end
            end
            if (bad) break;
            m[k] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_update(input logic [ISSUE_W-1:0] m, input bit pr);
        if (rst) begin
            mq.delete();
            for (int r = 0; r < 32; r++) busy_until[r] = 0;
        end else begin
            for (int k = 0; k < ISSUE_W; k++) begin
                if (m[k] && mq[k][40] && wa_of(mq[k]) != 0) begin
                    if ((cls_of(mq[k]) & C_MRD) != 0)     busy_until[wa_of(mq[k])] = cyc + LOAD_LAT + 1;
                    else if ((cls_of(mq[k]) & C_MC) != 0) busy_until[wa_of(mq[k])] = cyc + MC_LAT + 1;
                end
            end
            for (int k = 0; k < ISSUE_W; k++)
                if (m[k]) void'(mq.pop_front());
            if (flush) mq.delete();
            else if (pr && push_cnt > 0)
                for (int i = 0; i < int'(push_cnt); i++) mq.push_back(push_data[i*57 +: 57]);
        end
        cyc++;
    endtask

    task automatic step();
        logic [ISSUE_W-1:0] m;
        bit pr;
        #2;
        m  = model_mask(issue_ready, flush, single_issue);
        pr = (mq.size() <= DEPTH - ISSUE_W);
        if (!rst) begin
            check("occupancy", 64'(occupancy), 64'(mq.size()));
            check("push_ready", 64'(push_ready), 64'(pr));
            check("issue_valid", 64'(issue_valid), 64'(m));
            for (int k = 0; k < ISSUE_W && k < mq.size(); k++)
                check("issue_data", 64'(issue_data[k*57 +: 57]), 64'(mq[k]));
        end
        model_update(m, pr);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ir, input bit fl, input bit si, input int cnt,
                         input ent_t e0, input ent_t e1);
        issue_ready  = ir;
        flush        = fl;
        single_issue = si;
        push_cnt     = 2'(cnt);
        push_data    = {e1, e0};
    endtask

    task automatic expect_valid(input string tag, input logic [ISSUE_W-1:0] v);
        #1;
        check(tag, 64'(issue_valid), 64'(v));
    endtask

    function automatic ent_t alu(input int n);
        return mk(32'h2004 + 32'(n) * 8, 8'h00, 1'b1, 5'd10, 5'd0, 5'd0, 1'b0);
    endfunction

    function automatic ent_t rnd_ent();
        logic [31:0] pc;
        logic [7:0]  cls;
        pc  = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 15) == 0) pc[11:0] = 12'h000;
        cls = 8'($urandom & $urandom & $urandom);
        if (cls[0]) cls[2] = 1'b0;
        return mk(pc, cls, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 7) == 0));
    endfunction

    initial begin
        int n;
        n = 0;
        rst = 1'b1;
        drive(0, 0, 0, 0, '0, '0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_push_ready", 64'(push_ready), 64'd1);
        check("rst_issue_valid", 64'(issue_valid), 64'd0);

        drive(1, 0, 0, 2, mk(32'h100, 8'h00, 1, 5'd1, 0, 0, 0), mk(32'h104, 8'h00, 1, 5'd2, 0, 0, 0));
        step();
        drive(1, 0, 0, 0, '0, '0);
        expect_valid("alu_pair", 2'b11);
        check("alu_occ_before", 64'(occupancy), 64'd2);
        step();
        check("alu_occ_after", 64'(occupancy), 64'd0);

        drive(1, 0, 0, 2, mk(32'h200, C_MRD, 1, 5'd3, 0, 0, 0), mk(32'h204, 8'h00, 1, 5'd4, 5'd3, 0, 0));
        step();
        drive(1, 0, 0, 0, '0, '0);
        expect_valid("load_first", 2'b01); step();
        expect_valid("load_stall1", 2'b00); step();
        expect_valid("load_stall2", 2'b00); step();
        expect_valid("load_use", 2'b01); step();

        drive(1, 0, 0, 2, mk(32'h300, C_MWR, 0, 0, 5'd1, 5'd2, 0), mk(32'h304, C_MRD, 1, 5'd5, 5'd1, 0, 0));
        step();
        drive(1, 0, 0, 0, '0, '0);
        expect_valid("store_alone", 2'b01); step();
        expect_valid("load_alone", 2'b01); step();
        drive(1, 0, 0, 2, mk(32'h400, C_JMP, 0, 0, 0, 0, 0), mk(32'h404, 8'h00, 1, 5'd6, 0, 0, 1));
        step();
        drive(1, 0, 0, 1, mk(32'h408, 8'h00, 1, 5'd7, 0, 0, 0), '0);
        expect_valid("jump_alone", 2'b01); step();
        drive(1, 0, 0, 0, '0, '0);
        expect_valid("delay_slot_alone", 2'b01); step();
        expect_valid("after_delay_slot", 2'b01); step();

        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 2, alu(n), alu(n + 1));
            n += 2;
            step();
        end
        check("full_push_ready", 64'(push_ready), 64'd0);
        check("full_occupancy", 64'(occupancy), 64'd8);
        for (int round = 0; round < 3; round++) begin
            drive(1, 0, 0, 0, '0, '0);
            for (int i = 0; i < 5; i++) step();
            for (int i = 0; i < 4; i++) begin
                drive(0, 0, 0, (i == 0) ? 1 : 2, alu(n), alu(n + 1));
                n += 2;
                step();
            end
            drive(0, 0, 0, 2, alu(n), alu(n + 1));
            n += 2;
            #1;
            check("round_push_ready", 64'(push_ready), 64'd0);
            step();
            check("round_occupancy", 64'(occupancy), 64'd7);
        end
        drive(1, 0, 0, 0, '0, '0);
        for (int i = 0; i < 5; i++) step();

        drive(1, 0, 1, 2, alu(n), alu(n + 1)); n += 2;
        step();
        drive(1, 0, 1, 2, alu(n), alu(n + 1)); n += 2;
        expect_valid("single_issue_a", 2'b01); step();
        drive(1, 0, 1, 0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            expect_valid("single_issue_b", 2'b01);
            step();
        end
        drive(1, 0, 0, 2, mk(32'h0FFC, 8'h00, 1, 5'd8, 0, 0, 0), mk(32'h1000, 8'h00, 1, 5'd9, 0, 0, 0));
        step();
        drive(1, 0, 0, 0, '0, '0);
        expect_valid("page_cross_a", 2'b01); step();
        expect_valid("page_cross_b", 2'b01); step();

        drive(0, 0, 0, 2, alu(n), alu(n + 1)); n += 2; step();
        drive(0, 0, 0, 2, alu(n), alu(n + 1)); n += 2; step();
        drive(0, 0, 0, 1, alu(n), alu(n + 1)); n += 2; step();
        check("pre_flush_occ", 64'(occupancy), 64'd5);
        drive(1, 1, 0, 2, alu(n), alu(n + 1)); n += 2;
        expect_valid("flush_valid", 2'b00);
        step();
        check("post_flush_occ", 64'(occupancy), 64'd0);

        drive(1, 0, 0, 1, mk(32'h500, C_MC, 1, 5'd7, 0, 0, 0), '0); step();
        drive(1, 0, 0, 0, '0, '0);
        expect_valid("mc_issue", 2'b01); step();
        drive(1, 1, 0, 0, '0, '0); step();
        drive(1, 0, 0, 1, mk(32'h504, 8'h00, 1, 5'd11, 5'd7, 0, 0), '0); step();
        drive(1, 0, 0, 0, '0, '0);
        expect_valid("mc_hold", 2'b00); step();
        expect_valid("mc_release", 2'b01); step();

        drive(1, 0, 0, 2, mk(32'h600, C_MRD, 1, 5'd9, 0, 0, 0), mk(32'h604, 8'h00, 1, 5'd12, 5'd9, 0, 0));
        step();
        drive(1, 0, 0, 0, '0, '0);
        expect_valid("stall_load", 2'b01); step();
        expect_valid("stall_wait", 2'b00);
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_mid_occ", 64'(occupancy), 64'd0);
        drive(1, 0, 0, 1, mk(32'h608, 8'h00, 1, 5'd13, 5'd9, 0, 0), '0); step();
        drive(1, 0, 0, 0, '0, '0);
        expect_valid("post_rst_issue", 2'b01); step();

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 255) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, ISSUE_W), rnd_ent(), rnd_ent());
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_issue_scheduler.md
Name: multi_issue_scheduler

Overview:
- Parametrised N-wide in-order issue stage between decode and the register-read/EX pipes.
- Decoded instructions are buffered in a circular queue.
- Each cycle it issues the longest legal in-order prefix (up to ISSUE_W) from the queue head, applying the pairing rules below.
- A per-register latency scoreboard holds back consumers of in-flight loads and multicycle ops.
- A run-time single-issue mode is provided for debug.

Parameters:
- ISSUE_W, 2, issue slots per cycle (1..4); also the maximum number of pushes per cycle.
- DEPTH, 8, queue entries; power of two, >= 2*ISSUE_W.
- LOAD_LAT, 2, cycles a load destination stays busy after issue.
- MC_LAT, 3, cycles a multicycle-op destination stays busy after issue.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all queued entries (exception/branch recovery).
- single_issue  in  1  when 1, at most slot 0 issues.
- push_cnt  in  $clog2(ISSUE_W+1)  number of entries offered this cycle (0..ISSUE_W).
- push_data  in  ISSUE_W*57  entries, slot i at bits [57i+56:57i].
- push_ready  out  1  1 iff free entries >= ISSUE_W.
- issue_ready  in  1  downstream accepts a group this cycle.
- issue_valid  out  ISSUE_W  in-order prefix mask of issued slots.
- issue_data  out  ISSUE_W*57  entries at queue head..head+ISSUE_W-1.
- occupancy  out  $clog2(DEPTH+1)  current entry count.

Entry layout, LSB first:
- pc[31:0]
- cls[7:0] = {ssnop, fpu_mutex, priv, jump, cond_move, multicycle, mem_wr, mem_rd}
- we
- waddr[4:0]
- raddr1[4:0]
- raddr2[4:0]
- delayslot

Behaviour:

Reset and occupancy:
- On rst: queue empty, head=tail=0, all scoreboard counters 0, issue_valid=0, occupancy=0, push_ready=1.
- Push accepted iff push_ready && push_cnt>0; entries 0..push_cnt-1 are written at tail in order.
- push_ready uses the pre-pop count (conservative); a pushed entry is issuable from the next cycle.
- Pointers wrap modulo DEPTH.
- occupancy_next = occupancy + pushed - issued.

Issue rules (combinational on registered queue/scoreboard state):
- Slot k is a candidate iff: k < occupancy, issue_ready=1, flush=0, !(single_issue && k>0), and neither nonzero raddr of slot k has a busy scoreboard counter.
- Slot 0 issues iff it is a candidate; nothing else gates it.
- Slot k>0 issues iff slot k-1 issued and slot k is a candidate, and none of the following hold for any issued j<k:
  - ssnop in j or k;
  - fpu_mutex, priv or jump in k;
  - jump or delayslot in j;
  - (mem_rd|mem_wr) in both j and k;
  - RAW hazard: j.we && j.waddr!=0 && j.waddr in {k.raddr1, k.raddr2}, and (j.mem_rd || j.multicycle || k.cond_move);
  - k.pc[11:0]==0 (possible TLB page crossing).
- issue_valid is always a contiguous prefix (e.g. 2'b10 is illegal).
- Head advances by popcount(issue_valid).

Scoreboard:
- 32 counters.
- Each cycle, every nonzero counter decrements by 1.
- For each issued slot with we && waddr!=0 && mem_rd, the counter for waddr is loaded with LOAD_LAT; with multicycle, it is loaded with MC_LAT.
- A load overrides the decrement for that register.
- If several issued slots target the same register, the highest slot wins.
- r0 is never busy.

Flush:
- flush=1 forces issue_valid=0 that cycle and empties the queue next cycle.
- A simultaneous push is dropped.
- Scoreboard keeps counting.

Test Plan:
- Reset, then push 2 independent ALU ops (pc 0x100, 0x104), issue_ready=1 -> next cycle issue_valid=2'b11, occupancy 2→0.
- Load $3 at 0x200 followed by add reading $3 -> first cycle valid=2'b01; add stalls exactly LOAD_LAT cycles, then issues in slot 0.
- Store then load (two mem ops) -> 2'b01 then 2'b01; jump followed by its delay slot -> delay slot issues alone, and the entry after it is not paired with it.
- Fill queue to DEPTH with issue_ready=0 -> push_ready=0 once free<ISSUE_W, occupancy=8, no overwrite; pointers wrap correctly after draining 3 full rounds.
- single_issue=1 with 4 independent ops -> exactly one issues per cycle; second slot at pc 0x1000 with single_issue=0 -> 2'b01.
- flush while occupancy=5 with a simultaneous push of 2 -> issue_valid=0, occupancy=0 next cycle, scoreboard busy register still clears on schedule; rst mid-stall clears everything.
